// File: rtl/twoscomp_arb.sv
// Round-robin arbiter sharing one two's-complement (pass/negate/abs) unit among
// NREQ requesters. The winner's operand is processed combinationally and captured
// in a single-entry output stage; a draining result frees the slot the same cycle.
module twoscomp_arb #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_ovf
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDW-1:0]   LAST_ID  = IDW'(NREQ - 1);

  logic [IDW-1:0]   ptr;
  logic             free;
  logic             found;
  logic [IDW-1:0]   win_id;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] win_data;
  logic [WIDTH-1:0] neg_data;
  logic             is_most_neg;
  logic [WIDTH-1:0] res_data;
  logic             res_ovf;
  logic             xfer;
  logic [IDW-1:0]   ptr_next;

  // a result leaving this cycle makes room for a new one on the same edge
  assign free = !rsp_valid || rsp_ready;

  // rotating priority search starting at ptr; first valid requester wins
  always_comb begin : search
    int idx;
    found    = 1'b0;
    win_id   = '0;
    win_op   = '0;
    win_data = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        win_id   = IDW'(idx);
        win_op   = req_op[2*idx +: 2];
        win_data = req_data[WIDTH*idx +: WIDTH];
      end
    end
  end

  // one-hot grant, suppressed while the slot is busy or reset is asserted
  always_comb begin
    req_ready = '0;
    if (!rst && free && found) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign xfer        = |(req_valid & req_ready);
  assign ptr_next    = (win_id == LAST_ID) ? '0 : win_id + IDW'(1);
  assign neg_data    = ~win_data + WIDTH'(1);
  assign is_most_neg = (win_data == MOST_NEG);

  // shared datapath: most-negative operand wraps to itself and flags overflow
  always_comb begin
    res_data = win_data;
    res_ovf  = 1'b0;
    case (win_op)
      2'b01: begin
        res_data = neg_data;
        res_ovf  = is_most_neg;
      end
      2'b10: begin
        res_data = win_data[WIDTH-1] ? neg_data : win_data;
        res_ovf  = is_most_neg;
      end
      default: begin
        res_data = win_data;
        res_ovf  = 1'b0;
      end
    endcase
  end

  // output stage and round-robin pointer; drained results keep their last value
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_ovf   <= 1'b0;
      ptr       <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_data  <= res_data;
      rsp_id    <= win_id;
      rsp_ovf   <= res_ovf;
      ptr       <= ptr_next;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_twoscomp_arb.sv
// Self-checking bench: a 4-requester 8-bit instance driven by directed and random
// steps against a behavioural model, plus a 1-requester 32-bit instance.
module tb_twoscomp_arb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: WIDTH=8, NREQ=4
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ovf;

  // instance B: WIDTH=32, NREQ=1
  logic        rst1;
  logic [0:0]  b_valid;
  logic [0:0]  b_ready;
  logic [1:0]  b_op;
  logic [31:0] b_data;
  logic        b_rsp_valid;
  logic        b_rsp_ready;
  logic [31:0] b_rsp_data;
  logic [0:0]  b_rsp_id;
  logic        b_rsp_ovf;

  int vectors = 0;
  int errors  = 0;

  twoscomp_arb #(.WIDTH(8), .NREQ(4)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ovf(rsp_ovf)
  );

  twoscomp_arb #(.WIDTH(32), .NREQ(1)) dut_b (
    .clk(clk), .rst(rst1), .req_valid(b_valid), .req_ready(b_ready),
    .req_op(b_op), .req_data(b_data), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_id(b_rsp_id), .rsp_ovf(b_rsp_ovf)
  );

  // behavioural model state for instance A
  bit              m_valid;
  longint unsigned m_data;
  int              m_id;
  bit              m_ovf;
  int              m_ptr;

  // behavioural model state for instance B
  bit              mb_valid;
  longint unsigned mb_data;
  bit              mb_ovf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // arithmetic from the op definitions using modular integer arithmetic
  function automatic void ref_op(input logic [1:0] op, input longint unsigned d, input int w,
                                 output longint unsigned r, output bit ovf);
    longint unsigned modv = 64'd1 << w;
    longint unsigned minv = 64'd1 << (w - 1);
    longint unsigned neg  = (modv - d) % modv;
    r   = d;
    ovf = 1'b0;
    if (op == 2'b01) begin
      r   = neg;
      ovf = (d == minv);
    end else if (op == 2'b10) begin
      r   = (d >= minv) ? neg : d;
      ovf = (d == minv);
    end
  endfunction

  // one clock of instance A: apply inputs, check grant mid-cycle, check outputs after the edge
  task automatic step_a(input logic r, input logic [3:0] v, input logic [7:0] ops,
                        input logic [31:0] d, input logic rr);
    int              g;
    bit              free;
    logic [3:0]      exp_ready;
    longint unsigned res;
    bit              ovf;
    rst = r; req_valid = v; req_op = ops; req_data = d; rsp_ready = rr;
    #3;
    free      = !m_valid || rr;
    g         = -1;
    exp_ready = '0;
    if (!r && free) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && v[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    if (r) begin
      m_valid = 0; m_data = 0; m_id = 0; m_ovf = 0; m_ptr = 0;
    end else if (g >= 0) begin
      ref_op(ops[2*g +: 2], longint'(d[8*g +: 8]), 8, res, ovf);
      m_valid = 1; m_data = res; m_id = g; m_ovf = ovf; m_ptr = (g + 1) % 4;
    end else if (m_valid && rr) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    chk("rsp_data", 64'(rsp_data), m_data);
    chk("rsp_id", 64'(rsp_id), 64'(m_id));
    chk("rsp_ovf", 64'(rsp_ovf), 64'(m_ovf));
  endtask

  // one clock of instance B
  task automatic step_b(input logic r, input logic v, input logic [1:0] op,
                        input logic [31:0] d, input logic rr);
    bit              grant;
    longint unsigned res;
    bit              ovf;
    rst1 = r; b_valid = v; b_op = op; b_data = d; b_rsp_ready = rr;
    #3;
    grant = !r && (!mb_valid || rr) && v;
    chk("b_req_ready", 64'(b_ready), 64'(grant));
    if (r) begin
      mb_valid = 0; mb_data = 0; mb_ovf = 0;
    end else if (grant) begin
      ref_op(op, longint'(d), 32, res, ovf);
      mb_valid = 1; mb_data = res; mb_ovf = ovf;
    end else if (mb_valid && rr) begin
      mb_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("b_rsp_valid", 64'(b_rsp_valid), 64'(mb_valid));
    chk("b_rsp_data", 64'(b_rsp_data), mb_data);
    chk("b_rsp_id", 64'(b_rsp_id), 64'd0);
    chk("b_rsp_ovf", 64'(b_rsp_ovf), 64'(mb_ovf));
  endtask

  logic [1:0]  t3_op   [6] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b00, 2'b11};
  logic [7:0]  t3_in   [6] = '{8'h80, 8'h80, 8'hFB, 8'h00, 8'h80, 8'h7F};
  logic [7:0]  t3_out  [6] = '{8'h80, 8'h80, 8'h05, 8'h00, 8'h80, 8'h7F};
  logic        t3_ovf  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    logic [7:0] held_data;
    logic [1:0] held_id;
    rst = 1; req_valid = 0; req_op = 0; req_data = 0; rsp_ready = 1;
    rst1 = 1; b_valid = 0; b_op = 0; b_data = 0; b_rsp_ready = 1;
    m_valid = 0; m_data = 0; m_id = 0; m_ovf = 0; m_ptr = 0;
    mb_valid = 0; mb_data = 0; mb_ovf = 0;
    @(posedge clk);
    #1;

    // reset state
    step_a(1, 4'hF, 8'h00, 32'h0, 1);
    step_b(1, 1'b1, 2'b00, 32'h0, 1);
    chk("reset_valid", 64'(rsp_valid), 64'd0);
    chk("reset_data", 64'(rsp_data), 64'd0);

    // 1: single requester 2 negates 0x05
    step_a(0, 4'b0100, 8'b0001_0000, 32'h0005_0000, 1);
    chk("t1_data", 64'(rsp_data), 64'hFB);
    chk("t1_id", 64'(rsp_id), 64'd2);
    step_a(0, 4'b1111, 8'h00, 32'h0, 1);
    chk("t1_ptr_next", 64'(rsp_id), 64'd3);

    // 2: all valid, ids rotate from 0
    step_a(1, 4'h0, 8'h00, 32'h0, 1);
    for (int i = 0; i < 8; i++) begin
      step_a(0, 4'hF, 8'h55, 32'h0403_0201 + 32'(i), 1);
      chk("t2_id_seq", 64'(rsp_id), 64'(i % 4));
      chk("t2_valid", 64'(rsp_valid), 64'd1);
    end

    // 3: op table on requester 0, draining between ops
    for (int i = 0; i < 6; i++) begin
      step_a(0, 4'b0001, {6'b0, t3_op[i]}, {24'h0, t3_in[i]}, 1);
      chk("t3_data", 64'(rsp_data), 64'(t3_out[i]));
      chk("t3_ovf", 64'(rsp_ovf), 64'(t3_ovf[i]));
      step_a(0, 4'b0000, 8'h00, 32'h0, 1);
    end

    // 4: stall with all valid, then release
    step_a(0, 4'hF, 8'hAA, 32'h1122_3344, 0);
    held_data = rsp_data;
    held_id   = rsp_id;
    for (int i = 0; i < 3; i++) begin
      step_a(0, 4'hF, 8'hAA, 32'h5566_7788, 0);
      chk("t4_stable_data", 64'(rsp_data), 64'(held_data));
      chk("t4_stable_id", 64'(rsp_id), 64'(held_id));
    end
    step_a(0, 4'hF, 8'h00, 32'h99AA_BBCC, 1);
    chk("t4_rr_continue", 64'(rsp_id), 64'((held_id + 1) % 4));

    // 5: reset while holding a result with ptr=2
    step_a(1, 4'h0, 8'h00, 32'h0, 1);
    step_a(0, 4'b0010, 8'h00, 32'h0000_4200, 0);
    step_a(1, 4'hF, 8'h00, 32'h0, 0);
    chk("t5_valid", 64'(rsp_valid), 64'd0);
    chk("t5_id", 64'(rsp_id), 64'd0);
    step_a(0, 4'b1010, 8'h00, 32'h0, 1);
    chk("t5_grant", 64'(rsp_id), 64'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step_a(($urandom_range(0, 39) == 0), 4'($urandom), 8'($urandom),
             ($urandom_range(0, 3) == 0) ? 32'h8080_8080 : $urandom,
             ($urandom_range(0, 3) != 0));
    end

    // 6: single requester, 32-bit, back-to-back
    step_b(0, 1'b1, 2'b01, 32'h0000_0001, 1);
    chk("t6_data", 64'(b_rsp_data), 64'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      step_b(0, 1'b1, 2'(i), 32'h8000_0000 + 32'(i * 7), 1);
      chk("t6_b2b_valid", 64'(b_rsp_valid), 64'd1);
    end
    for (int i = 0; i < 100; i++) begin
      step_b(($urandom_range(0, 29) == 0), 1'($urandom), 2'($urandom),
             ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom,
             ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
